// File: rtl/ddma_mem_reader.sv
// Memory-to-NoC DMA reader: reads a run of words from local memory and serializes them MSB-first into flits.
// Optional header flit carrying the payload flit count is enabled by defining DDMA_HEADER_EN.
module ddma_mem_reader #(
    parameter int unsigned MEMORY_BUS_WIDTH = 32,
    parameter int unsigned FLIT_WIDTH       = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [MEMORY_BUS_WIDTH-3:0] addr_in,
    input  logic [MEMORY_BUS_WIDTH-3:0] nbytes_in,
    input  logic                        cmd_in,
    output logic [4:0]                  status_out,
    output logic [4:0]                  irq_out,
    output logic [MEMORY_BUS_WIDTH-3:0] mem_addr_out,
    output logic                        mem_rd_out,
    input  logic [MEMORY_BUS_WIDTH-1:0] mem_data_in,
    output logic [FLIT_WIDTH-1:0]       flit_out,
    output logic                        flit_valid_out,
    input  logic                        flit_ready_in
);

    localparam int unsigned MW  = MEMORY_BUS_WIDTH;
    localparam int unsigned AW  = MEMORY_BUS_WIDTH - 2;
    localparam int unsigned FW  = FLIT_WIDTH;
    localparam int unsigned R   = MW / FW;
    localparam int unsigned BPW = MW / 8;
    localparam int unsigned CW  = $clog2(R) + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_READ,
        ST_WAIT,
        ST_SEND,
        ST_DONE
    } state_t;

    state_t         r_state;
    logic           r_cmd_prev;
    logic [AW-1:0]  r_addr;
    logic [AW-1:0]  r_words_left;
    logic [CW-1:0]  r_flit_idx;
    logic [MW-1:0]  r_shift;
    logic [FW-1:0]  r_flit;
    logic           r_flit_valid;
    logic           r_mem_rd;
    logic [AW-1:0]  r_mem_addr;
    logic           r_busy;
    logic           r_done;
    logic           r_ovr;
    logic           r_zero;
    logic           r_irq_done;
    logic           r_irq_err;

    state_t         w_state_nxt;
    logic [AW-1:0]  w_addr_nxt;
    logic [AW-1:0]  w_words_left_nxt;
    logic [CW-1:0]  w_flit_idx_nxt;
    logic [MW-1:0]  w_shift_nxt;
    logic [FW-1:0]  w_flit_nxt;
    logic           w_flit_valid_nxt;
    logic           w_mem_rd_nxt;
    logic [AW-1:0]  w_mem_addr_nxt;
    logic           w_busy_nxt;
    logic           w_done_nxt;
    logic           w_ovr_nxt;
    logic           w_zero_nxt;
    logic           w_irq_done_nxt;
    logic           w_irq_err_nxt;

    logic           w_rise;
    logic           w_hs;
    logic           w_last;
    logic [AW:0]    w_nbytes_rnd;
    logic [AW-1:0]  w_nwords;

    assign w_rise       = cmd_in & ~r_cmd_prev;
    assign w_hs         = r_flit_valid & flit_ready_in;
    assign w_last       = (r_flit_idx == CW'(R - 1));
    // Round the byte count up to whole words; one extra bit keeps the carry.
    assign w_nbytes_rnd = {1'b0, nbytes_in} + (AW+1)'(BPW - 1);
    assign w_nwords     = AW'(w_nbytes_rnd / (AW+1)'(BPW));

    assign status_out     = {1'b0, r_zero, r_ovr, r_done, r_busy};
    assign irq_out        = {3'b000, r_irq_err, r_irq_done};
    assign mem_addr_out   = r_mem_addr;
    assign mem_rd_out     = r_mem_rd;
    assign flit_out       = r_flit;
    assign flit_valid_out = r_flit_valid;

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_cmd_prev   <= 1'b0;
            r_addr       <= '0;
            r_words_left <= '0;
            r_flit_idx   <= '0;
            r_shift      <= '0;
            r_flit       <= '0;
            r_flit_valid <= 1'b0;
            r_mem_rd     <= 1'b0;
            r_mem_addr   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_ovr        <= 1'b0;
            r_zero       <= 1'b0;
            r_irq_done   <= 1'b0;
            r_irq_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cmd_prev   <= cmd_in;
            r_addr       <= w_addr_nxt;
            r_words_left <= w_words_left_nxt;
            r_flit_idx   <= w_flit_idx_nxt;
            r_shift      <= w_shift_nxt;
            r_flit       <= w_flit_nxt;
            r_flit_valid <= w_flit_valid_nxt;
            r_mem_rd     <= w_mem_rd_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_ovr        <= w_ovr_nxt;
            r_zero       <= w_zero_nxt;
            r_irq_done   <= w_irq_done_nxt;
            r_irq_err    <= w_irq_err_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt      = r_state;
        w_addr_nxt       = r_addr;
        w_words_left_nxt = r_words_left;
        w_flit_idx_nxt   = r_flit_idx;
        w_shift_nxt      = r_shift;
        w_flit_nxt       = r_flit;
        w_flit_valid_nxt = r_flit_valid;
        w_mem_rd_nxt     = 1'b0;
        w_mem_addr_nxt   = r_mem_addr;
        w_busy_nxt       = r_busy;
        w_done_nxt       = r_done;
        w_ovr_nxt        = r_ovr;
        w_zero_nxt       = r_zero;
        w_irq_done_nxt   = r_irq_done;
        w_irq_err_nxt    = r_irq_err;

        // A new request while a transfer is in flight is flagged, never acted on.
        if (w_rise && (r_state != ST_IDLE)) begin
            w_ovr_nxt     = 1'b1;
            w_irq_err_nxt = 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_busy_nxt       = 1'b1;
                    w_done_nxt       = 1'b0;
                    w_ovr_nxt        = 1'b0;
                    w_zero_nxt       = 1'b0;
                    w_irq_done_nxt   = 1'b0;
                    w_irq_err_nxt    = 1'b0;
                    w_addr_nxt       = addr_in;
                    w_words_left_nxt = w_nwords;
                    w_flit_idx_nxt   = '0;
                    if (nbytes_in == '0) begin
                        w_zero_nxt  = 1'b1;
                        w_state_nxt = ST_DONE;
                    end else begin
`ifdef DDMA_HEADER_EN
                        w_state_nxt      = ST_HEADER;
                        w_flit_valid_nxt = 1'b1;
                        w_flit_nxt       = FW'((AW+FW)'(w_nwords) * (AW+FW)'(R));
`else
                        w_state_nxt      = ST_READ;
                        w_mem_rd_nxt     = 1'b1;
                        w_mem_addr_nxt   = addr_in;
`endif
                    end
                end
            end
            ST_HEADER: begin
                if (w_hs) begin
                    w_flit_valid_nxt = 1'b0;
                    w_state_nxt      = ST_READ;
                    w_mem_rd_nxt     = 1'b1;
                    w_mem_addr_nxt   = r_addr;
                end
            end
            ST_READ: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                w_flit_nxt       = mem_data_in[MW-1 -: FW];
                w_shift_nxt      = mem_data_in << FW;
                w_flit_idx_nxt   = '0;
                w_flit_valid_nxt = 1'b1;
                w_state_nxt      = ST_SEND;
            end
            ST_SEND: begin
                if (w_hs) begin
                    if (w_last) begin
                        w_flit_valid_nxt = 1'b0;
                        if (r_words_left > AW'(1)) begin
                            w_words_left_nxt = r_words_left - AW'(1);
                            w_addr_nxt       = r_addr + AW'(1);
                            w_mem_addr_nxt   = r_addr + AW'(1);
                            w_mem_rd_nxt     = 1'b1;
                            w_state_nxt      = ST_READ;
                        end else begin
                            w_state_nxt = ST_DONE;
                        end
                    end else begin
                        w_flit_idx_nxt = r_flit_idx + CW'(1);
                        w_flit_nxt     = r_shift[MW-1 -: FW];
                        w_shift_nxt    = r_shift << FW;
                    end
                end
            end
            ST_DONE: begin
                w_busy_nxt     = 1'b0;
                w_done_nxt     = 1'b1;
                w_irq_done_nxt = 1'b1;
                w_state_nxt    = ST_IDLE;
            end
            default: begin
                w_state_nxt      = ST_IDLE;
                w_flit_valid_nxt = 1'b0;
                w_busy_nxt       = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ddma_mem_reader.sv
// Scoreboard bench for ddma_mem_reader: a behavioural model queues expected flits and read addresses,
// independent monitors pop and compare whenever the DUT presents a flit or a read strobe.
module tb_ddma_mem_reader;

`ifdef DDMA_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int R = 2;

    logic        clock;
    logic        reset;
    logic [29:0] addr_in;
    logic [29:0] nbytes_in;
    logic        cmd_in;
    logic [4:0]  status_out;
    logic [4:0]  irq_out;
    logic [29:0] mem_addr_out;
    logic        mem_rd_out;
    logic [31:0] mem_data_in;
    logic [15:0] flit_out;
    logic        flit_valid_out;
    logic        flit_ready_in;

    ddma_mem_reader #(.MEMORY_BUS_WIDTH(32), .FLIT_WIDTH(16)) dut (
        .clock          (clock),
        .reset          (reset),
        .addr_in        (addr_in),
        .nbytes_in      (nbytes_in),
        .cmd_in         (cmd_in),
        .status_out     (status_out),
        .irq_out        (irq_out),
        .mem_addr_out   (mem_addr_out),
        .mem_rd_out     (mem_rd_out),
        .mem_data_in    (mem_data_in),
        .flit_out       (flit_out),
        .flit_valid_out (flit_valid_out),
        .flit_ready_in  (flit_ready_in)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_flits[$];
    logic [29:0] exp_addrs[$];
    logic [31:0] mem_pre[logic [29:0]];

    int   acc = 0;
    int   rmode = 0;
    int   stall_left = 0;
    logic prev_stall = 1'b0;
    logic [15:0] prev_flit = '0;
    logic        rd_d = 1'b0;
    logic [29:0] rd_addr_d = '0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (actual=running required=finished)");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        if (mem_pre.exists(a)) return mem_pre[a];
        return ({2'b00, a} * 32'h9E3779B1) ^ 32'h5A5AC3C3;
    endfunction

    // Memory model: data appears one cycle after the read strobe and is garbage otherwise.
    always @(negedge clock) begin
        if (rd_d) mem_data_in = mem_word(rd_addr_d);
        else      mem_data_in = $urandom();
        rd_d      = mem_rd_out;
        rd_addr_d = mem_addr_out;
        if (reset && mem_rd_out) begin
            if (exp_addrs.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_extra actual=read@0x%0h required=no read", mem_addr_out);
            end else begin
                check("rd_addr", 32'(mem_addr_out), 32'(exp_addrs.pop_front()));
            end
        end
    end

    // Flit monitor: compares accepted flits and holds stalled flits to stability.
    always @(negedge clock) begin
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(flit_valid_out), 32'd1);
                check("stall_data", 32'(flit_out), 32'(prev_flit));
            end
            if (flit_valid_out && flit_ready_in) begin
                prev_stall = 1'b0;
                acc++;
                if (exp_flits.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL flit_extra actual=0x%0h required=no flit", flit_out);
                end else begin
                    check("flit", 32'(flit_out), 32'(exp_flits.pop_front()));
                end
            end else if (flit_valid_out) begin
                prev_stall = 1'b1;
                prev_flit  = flit_out;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    // Downstream ready driver.
    initial begin
        flit_ready_in = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            case (rmode)
                1: flit_ready_in = ($urandom_range(0, 3) != 0);
                2: begin
                    if (flit_valid_out && (acc == HDR + 1) && (stall_left > 0)) begin
                        flit_ready_in = 1'b0;
                        stall_left--;
                    end else begin
                        flit_ready_in = 1'b1;
                    end
                end
                default: flit_ready_in = 1'b1;
            endcase
        end
    end

    task automatic push_model(input logic [29:0] a, input logic [29:0] nb, output int nw);
        logic [29:0] wa;
        logic [31:0] d;
        nw = (int'(nb) + 3) / 4;
        if (HDR != 0 && nw > 0) exp_flits.push_back(16'(nw * R));
        for (int i = 0; i < nw; i++) begin
            wa = a + 30'(i);
            exp_addrs.push_back(wa);
            d = mem_word(wa);
            exp_flits.push_back(d[31:16]);
            exp_flits.push_back(d[15:0]);
        end
    endtask

    task automatic wait_done(input int exp_cyc, input int ovr_at, input logic exp_ovr, input logic exp_zero);
        int cyc = 0;
        bit ok = 0;
        while (cyc < 3000) begin
            @(negedge clock);
            cyc++;
            if (cyc == 1) begin
                addr_in   = 30'($urandom());
                nbytes_in = 30'($urandom());
            end
            if (ovr_at != 0 && cyc == ovr_at)     cmd_in = 1'b0;
            if (ovr_at != 0 && cyc == ovr_at + 1) cmd_in = 1'b1;
            if (status_out[1] && !status_out[0]) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=no done after %0d cycles required=done", cyc);
        end else if (exp_cyc >= 0) begin
            check("latency", 32'(cyc), 32'(exp_cyc));
        end
        check("status", 32'(status_out), 32'({1'b0, exp_zero, exp_ovr, 1'b1, 1'b0}));
        check("irq", 32'(irq_out), 32'({3'b000, exp_ovr, 1'b1}));
    endtask

    task automatic run_xfer(input logic [29:0] a, input logic [29:0] nb, input int mode, input int ovr_at);
        int nw;
        int lat;
        rmode      = mode;
        stall_left = 3;
        acc        = 0;
        push_model(a, nb, nw);
        lat = (nw == 0) ? 2 : 2 + HDR + nw * (2 + R);
        @(negedge clock);
        addr_in   = a;
        nbytes_in = nb;
        cmd_in    = 1'b1;
        wait_done((mode == 0) ? lat : -1, ovr_at, ovr_at != 0, nb == 0);
        @(negedge clock);
        cmd_in = 1'b0;
        repeat (3) @(negedge clock);
        check("idle_valid", 32'(flit_valid_out), 32'd0);
        check("flitq_empty", 32'(exp_flits.size()), 32'd0);
        check("addrq_empty", 32'(exp_addrs.size()), 32'd0);
        exp_flits.delete();
        exp_addrs.delete();
    endtask

    task automatic reset_mid();
        int nw;
        int cyc = 0;
        rmode = 0;
        acc   = 0;
        push_model(30'h20, 30'd16, nw);
        @(negedge clock);
        addr_in   = 30'h20;
        nbytes_in = 30'd16;
        cmd_in    = 1'b1;
        while (acc < HDR + 1 && cyc < 200) begin
            @(negedge clock);
            #1;
            cyc++;
        end
        check("reach_send", 32'(acc >= HDR + 1), 32'd1);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("rst_valid", 32'(flit_valid_out), 32'd0);
        check("rst_status", 32'(status_out), 32'd0);
        check("rst_irq", 32'(irq_out), 32'd0);
        check("rst_rd", 32'(mem_rd_out), 32'd0);
        exp_flits.delete();
        exp_addrs.delete();
        acc = 0;
        // cmd_in stays high across reset, so release must start a fresh transfer.
        push_model(30'h20, 30'd16, nw);
        @(negedge clock);
        addr_in   = 30'h20;
        nbytes_in = 30'd16;
        reset     = 1'b1;
        wait_done(2 + HDR + nw * (2 + R), 0, 1'b0, 1'b0);
        @(negedge clock);
        cmd_in = 1'b0;
        repeat (3) @(negedge clock);
        check("flitq_empty_rst", 32'(exp_flits.size()), 32'd0);
        check("addrq_empty_rst", 32'(exp_addrs.size()), 32'd0);
        exp_flits.delete();
        exp_addrs.delete();
    endtask

    initial begin
        logic [29:0] ra;
        reset     = 1'b0;
        cmd_in    = 1'b0;
        addr_in   = '0;
        nbytes_in = '0;
        mem_pre[30'h10] = 32'hAAAA5555;
        mem_pre[30'h11] = 32'h12345678;
        repeat (3) @(negedge clock);
        check("rst0_status", 32'(status_out), 32'd0);
        check("rst0_irq", 32'(irq_out), 32'd0);
        check("rst0_valid", 32'(flit_valid_out), 32'd0);
        check("rst0_flit", 32'(flit_out), 32'd0);
        check("rst0_rd", 32'(mem_rd_out), 32'd0);
        check("rst0_addr", 32'(mem_addr_out), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        run_xfer(30'h10, 30'd8, 0, 0);
        run_xfer(30'h10, 30'd5, 0, 0);
        run_xfer(30'h40, 30'd0, 0, 0);
        run_xfer(30'h10, 30'd8, 2, 0);
        run_xfer(30'h3FFFFFFF, 30'd8, 0, 0);
        run_xfer(30'h100, 30'd24, 0, 3);
        run_xfer(30'h10, 30'd8, 0, 0);
        reset_mid();

        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 1) == 1) ra = 30'h3FFFFFFF - 30'($urandom_range(0, 3));
            else                           ra = 30'($urandom());
            run_xfer(ra, 30'($urandom_range(0, 40)), int'($urandom_range(0, 1)), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
